scaler_chain: RTL and testbench

SCALER_CHAIN -- requirements
Module: scaler_chain

---
 rtl/scaler_chain_pkg.sv | 11 +
 rtl/scaler_chan_read.sv | 82 ++++++++
 rtl/scaler_chain.sv | 99 +++++++++
 tb/tb_scaler_chain.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_chain_pkg.sv
// Shared constants for the scaler chain.
//   SCALER_STAGES  : default highest stage number (stages 2..SCALER_STAGES)
//   SCALER_CHAN_LO : default stage number mapped to bit 0 of the lower channel field
//   SCALER_CHAN_W  : default width of each channel field
package scaler_chain_pkg;

    localparam int unsigned SCALER_STAGES  = 33;
    localparam int unsigned SCALER_CHAN_LO = 6;
    localparam int unsigned SCALER_CHAN_W  = 14;

endpackage

// File: rtl/scaler_chan_read.sv
// Channel read-out for the scaler chain: read-strobe edge detection, upper-field
// snapshot (snap/snapv) and the registered CHAT/CHBT read data.
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous active-low reset
//   sclr_ni    : active-low scaler clear, invalidates the snapshot
//   rchat_ni   : active-low read strobe, lower field; its falling edge snapshots the upper field
//   rchbt_ni   : active-low read strobe, upper field
//   lo_field_i : live lower channel field of the counter
//   hi_field_i : live upper channel field of the counter
//   chat_o     : registered lower field read data, zero when not read
//   chbt_o     : registered upper field read data (snapshot or live), zero when not read
module scaler_chan_read
    import scaler_chain_pkg::*;
#(
    parameter int unsigned CHAN_W = SCALER_CHAN_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sclr_ni,
    input  logic              rchat_ni,
    input  logic              rchbt_ni,
    input  logic [CHAN_W-1:0] lo_field_i,
    input  logic [CHAN_W-1:0] hi_field_i,
    output logic [CHAN_W-1:0] chat_o,
    output logic [CHAN_W-1:0] chbt_o
);

    logic              rchat_q;
    logic              rchbt_q;
    logic              snapv_q;
    logic [CHAN_W-1:0] snap_q;
    logic [CHAN_W-1:0] chat_q;
    logic [CHAN_W-1:0] chbt_q;
    logic              rchat_fall;
    logic              rchbt_rise;

    assign rchat_fall = ~rchat_ni & rchat_q;
    assign rchbt_rise = rchbt_ni & ~rchbt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rchat_q <= 1'b1;
            rchbt_q <= 1'b1;
            snapv_q <= 1'b0;
            snap_q  <= '0;
            chat_q  <= '0;
            chbt_q  <= '0;
        end else begin
            rchat_q <= rchat_ni;
            rchbt_q <= rchbt_ni;
            chat_q  <= rchat_ni ? '0 : lo_field_i;

            // A lower-field read starting this cycle captures the same counter
            // sample, so the live field is what the snapshot is about to hold.
            if (rchbt_ni) begin
                chbt_q <= '0;
            end else if (rchat_fall || !snapv_q) begin
                chbt_q <= hi_field_i;
            end else begin
                chbt_q <= snap_q;
            end

            if (rchat_fall) begin
                snap_q <= hi_field_i;
            end

            // Clear beats a fresh capture: a snapshot of the pre-clear count is stale.
            if (!sclr_ni) begin
                snapv_q <= 1'b0;
            end else if (rchat_fall) begin
                snapv_q <= 1'b1;
            end else if (rchbt_rise) begin
                snapv_q <= 1'b0;
            end
        end
    end

    assign chat_o = chat_q;
    assign chbt_o = chbt_q;

endmodule

// File: rtl/scaler_chain.sv
// Ripple-style scaler chain modelled as a binary counter whose bit i is scaler
// stage i+2, with per-stage rising/falling pulses, a full-scale wrap pulse and
// two channel read ports.
// Ports:
//   SIM_CLK  : sole clock, rising edge
//   SIM_RST_ : synchronous active-low reset
//   FS01_    : active-low tick, one count per cycle held low
//   SCLR_    : active-low synchronous clear, wins over a tick
//   RCHAT_   : active-low read strobe, lower channel field
//   RCHBT_   : active-low read strobe, upper channel field
//   FS       : stage levels, FS[i] is stage i+2
//   FA       : one-cycle pulse per stage on 0->1
//   FB       : one-cycle pulse per stage on 1->0
//   CHAT     : lower channel read data
//   CHBT     : upper channel read data
//   SCOVF    : one-cycle pulse on full-scale wrap by tick
module scaler_chain
    import scaler_chain_pkg::*;
#(
    parameter int unsigned STAGES  = SCALER_STAGES,
    parameter int unsigned CHAN_LO = SCALER_CHAN_LO,
    parameter int unsigned CHAN_W  = SCALER_CHAN_W
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST_,
    input  logic              FS01_,
    input  logic              SCLR_,
    input  logic              RCHAT_,
    input  logic              RCHBT_,
    output logic [STAGES-2:0] FS,
    output logic [STAGES-2:0] FA,
    output logic [STAGES-2:0] FB,
    output logic [CHAN_W-1:0] CHAT,
    output logic [CHAN_W-1:0] CHBT,
    output logic              SCOVF
);

    localparam int unsigned CntW   = STAGES - 1;
    localparam int unsigned LoBase = CHAN_LO - 2;
    localparam int unsigned HiBase = LoBase + CHAN_W;

    if ((STAGES < 8) || (STAGES > 33) || (CHAN_LO < 2) || (CHAN_W < 1) ||
        (CHAN_LO + 2 * CHAN_W - 1 > STAGES)) begin : gen_param_check
        $error("scaler_chain: illegal STAGES/CHAN_LO/CHAN_W combination");
    end

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic [CntW-1:0] fa_q;
    logic [CntW-1:0] fb_q;
    logic            scovf_q;
    logic            wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (!SCLR_) begin
            cnt_d = '0;
        end else if (!FS01_) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Only a tick can overflow; a clear from all-ones is not a wrap.
    assign wrap = SCLR_ & ~FS01_ & (&cnt_q);

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST_) begin
            cnt_q   <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            scovf_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fa_q    <= cnt_d & ~cnt_q;
            fb_q    <= cnt_q & ~cnt_d;
            scovf_q <= wrap;
        end
    end

    assign FS    = cnt_q;
    assign FA    = fa_q;
    assign FB    = fb_q;
    assign SCOVF = scovf_q;

    scaler_chan_read #(
        .CHAN_W (CHAN_W)
    ) u_chan_read (
        .clk_i      (SIM_CLK),
        .rst_ni     (SIM_RST_),
        .sclr_ni    (SCLR_),
        .rchat_ni   (RCHAT_),
        .rchbt_ni   (RCHBT_),
        .lo_field_i (cnt_q[LoBase +: CHAN_W]),
        .hi_field_i (cnt_q[HiBase +: CHAN_W]),
        .chat_o     (CHAT),
        .chbt_o     (CHBT)
    );

endmodule

// File: tb/tb_scaler_chain.sv
module tb_scaler_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, fs01_n, sclr_n, rchat_n, rchbt_n;

    // Instance A: default parameters (32-bit count, fields at CNT[17:4] / CNT[31:18]).
    logic [31:0] fs_a, fa_a, fb_a;
    logic [13:0] chat_a, chbt_a;
    logic        scovf_a;
    // Instance B: STAGES=8, CHAN_LO=2, CHAN_W=3 (7-bit count, fields CNT[2:0] / CNT[5:3]).
    logic [6:0]  fs_b, fa_b, fb_b;
    logic [2:0]  chat_b, chbt_b;
    logic        scovf_b;

    scaler_chain dut_a (
        .SIM_CLK (clk), .SIM_RST_ (rst_n), .FS01_ (fs01_n), .SCLR_ (sclr_n),
        .RCHAT_ (rchat_n), .RCHBT_ (rchbt_n), .FS (fs_a), .FA (fa_a), .FB (fb_a),
        .CHAT (chat_a), .CHBT (chbt_a), .SCOVF (scovf_a)
    );

    scaler_chain #(.STAGES (8), .CHAN_LO (2), .CHAN_W (3)) dut_b (
        .SIM_CLK (clk), .SIM_RST_ (rst_n), .FS01_ (fs01_n), .SCLR_ (sclr_n),
        .RCHAT_ (rchat_n), .RCHBT_ (rchbt_n), .FS (fs_b), .FA (fa_b), .FB (fb_b),
        .CHAT (chat_b), .CHBT (chbt_b), .SCOVF (scovf_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: counter value as an integer, reads as field extraction.
    longint unsigned m_cnt [2];
    longint unsigned m_snap [2];
    bit              m_snapv, m_prev_rchat, m_prev_rchbt;
    longint unsigned e_fs [2], e_fa [2], e_fb [2], e_chat [2], e_chbt [2];
    bit              e_scovf [2];

    function automatic longint unsigned cmask(int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'h7F;
    endfunction
    function automatic int lo_base(int k);
        return (k == 0) ? 4 : 0;
    endfunction
    function automatic int fw(int k);
        return (k == 0) ? 14 : 3;
    endfunction
    function automatic longint unsigned fld(longint unsigned v, int base, int w);
        return (v >> base) & ((64'd1 << w) - 1);
    endfunction

    task automatic model_step(input bit r, input bit t, input bit c, input bit a, input bit b);
        bit fall;
        fall = !a && m_prev_rchat;
        for (int k = 0; k < 2; k++) begin
            longint unsigned old_v, new_v, hi_v;
            if (!r) begin
                m_cnt[k] = 0; m_snap[k] = 0;
                e_fs[k] = 0; e_fa[k] = 0; e_fb[k] = 0;
                e_chat[k] = 0; e_chbt[k] = 0; e_scovf[k] = 0;
            end else begin
                old_v = m_cnt[k];
                if (!c)      new_v = 0;
                else if (!t) new_v = (old_v + 1) & cmask(k);
                else         new_v = old_v;
                hi_v = fld(old_v, lo_base(k) + fw(k), fw(k));
                e_fs[k]    = new_v;
                e_fa[k]    = new_v & ~old_v;
                e_fb[k]    = old_v & ~new_v;
                e_scovf[k] = c && !t && (old_v == cmask(k));
                e_chat[k]  = a ? 0 : fld(old_v, lo_base(k), fw(k));
                e_chbt[k]  = b ? 0 : ((fall || !m_snapv) ? hi_v : m_snap[k]);
                if (fall) m_snap[k] = hi_v;
                m_cnt[k] = new_v;
            end
        end
        if (!r) begin
            m_snapv = 0; m_prev_rchat = 1; m_prev_rchbt = 1;
        end else begin
            if (!c)                        m_snapv = 0;
            else if (fall)                 m_snapv = 1;
            else if (b && !m_prev_rchbt)   m_snapv = 0;
            m_prev_rchat = a;
            m_prev_rchbt = b;
        end
    endtask

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("a.fs", 64'(fs_a), e_fs[0]);
        check("a.fa", 64'(fa_a), e_fa[0]);
        check("a.fb", 64'(fb_a), e_fb[0]);
        check("a.chat", 64'(chat_a), e_chat[0]);
        check("a.chbt", 64'(chbt_a), e_chbt[0]);
        check("a.scovf", 64'(scovf_a), 64'(e_scovf[0]));
        check("b.fs", 64'(fs_b), e_fs[1]);
        check("b.fa", 64'(fa_b), e_fa[1]);
        check("b.fb", 64'(fb_b), e_fb[1]);
        check("b.chat", 64'(chat_b), e_chat[1]);
        check("b.chbt", 64'(chbt_b), e_chbt[1]);
        check("b.scovf", 64'(scovf_b), 64'(e_scovf[1]));
    endtask

    // Drive one cycle of inputs (active-low values), advance past the edge, compare.
    task automatic step(input bit r, input bit t, input bit c, input bit a, input bit b);
        rst_n = r; fs01_n = t; sclr_n = c; rchat_n = a; rchbt_n = b;
        model_step(r, t, c, a, b);
        @(negedge clk);
        compare_model();
    endtask

    task automatic ticks(input int n, input bit b);
        for (int i = 0; i < n; i++) step(1, 0, 1, 1, b);
    endtask

    typedef struct {
        bit          rst, fs01, sclr;
        logic [31:0] fs, fa, fb;
        bit          scovf;
    } vec_t;

    vec_t tbl [8];

    initial begin
        rst_n = 0; fs01_n = 1; sclr_n = 1; rchat_n = 1; rchbt_n = 1;

        // Reset, five ticks, idle, then a plain clear from 5.
        tbl[0] = '{1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'd1, 32'd1, 32'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'd2, 32'd2, 32'd1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'd3, 32'd1, 32'd0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'd4, 32'd4, 32'd3, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'd5, 32'd1, 32'd0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'd5, 32'd0, 32'd0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd5, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rst, tbl[i].fs01, tbl[i].sclr, 1, 1);
            check($sformatf("tbl%0d.fs", i), 64'(fs_a), 64'(tbl[i].fs));
            check($sformatf("tbl%0d.fa", i), 64'(fa_a), 64'(tbl[i].fa));
            check($sformatf("tbl%0d.fb", i), 64'(fb_a), 64'(tbl[i].fb));
            check($sformatf("tbl%0d.scovf", i), 64'(scovf_a), 64'(tbl[i].scovf));
        end

        // Clear and tick together from 3: clear wins, no overflow.
        step(0, 1, 1, 1, 1);
        ticks(3, 1);
        check("clr.pre_fs", 64'(fs_a), 3);
        step(1, 0, 0, 1, 1);
        check("clr.fs", 64'(fs_a), 0);
        check("clr.fb", 64'(fb_a), 3);
        check("clr.fa", 64'(fa_a), 0);
        check("clr.scovf", 64'(scovf_a), 0);

        // Small instance wraps from 127 to 0.
        step(0, 1, 1, 1, 1);
        ticks(127, 1);
        check("ovf.pre_fs", 64'(fs_b), 127);
        step(1, 0, 1, 1, 1);
        check("ovf.fs", 64'(fs_b), 0);
        check("ovf.scovf", 64'(scovf_b), 1);
        check("ovf.fb", 64'(fb_b), 64'h7F);
        step(1, 1, 1, 1, 1);
        check("ovf.scovf_end", 64'(scovf_b), 0);

        // Snapshot read: count 45 (upper 5, lower 5), three ticks to 48 (upper 6).
        step(0, 1, 1, 1, 1);
        ticks(45, 1);
        step(1, 1, 1, 0, 1);
        check("snap.chat", 64'(chat_b), 5);
        ticks(3, 1);
        step(1, 1, 1, 1, 0);
        check("snap.chbt", 64'(chbt_b), 5);
        step(1, 1, 1, 1, 0);
        check("snap.chbt_hold", 64'(chbt_b), 5);
        step(1, 1, 1, 1, 1);
        check("snap.chbt_idle", 64'(chbt_b), 0);
        step(1, 1, 1, 1, 0);
        check("snap.chbt_live", 64'(chbt_b), 6);

        // Simultaneous first-cycle reads with an older valid snapshot: live field wins.
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 1, 1);
        ticks(8, 1);
        step(1, 1, 1, 0, 0);
        check("simul.chat", 64'(chat_b), 0);
        check("simul.chbt", 64'(chbt_b), 7);

        // Reset mid-count with a valid snapshot and RCHBT_ held low.
        step(1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check("rst.fs", 64'(fs_b), 0);
        check("rst.fb", 64'(fb_b), 0);
        check("rst.chbt", 64'(chbt_b), 0);
        check("rst.chat", 64'(chat_b), 0);
        step(1, 0, 1, 1, 0);
        check("rst.resume", 64'(fs_b), 1);
        ticks(9, 0);
        step(1, 1, 1, 1, 0);
        check("rst.chbt_live", 64'(chbt_b), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, t, c, a, b;
            r = ($urandom_range(0, 63) != 0);
            t = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 31) != 0);
            a = ($urandom_range(0, 7) != 0) ? rchat_n : ~rchat_n;
            b = ($urandom_range(0, 5) != 0) ? rchbt_n : ~rchbt_n;
            step(r, t, c, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
